// File: rtl/axi_stream_pkg.sv
// Shared AXI-Stream helpers: width ratio, parameter legality and optional-field widths.
package axi_stream_pkg;

    function automatic int unsigned calc_ratio(input int unsigned width_in, input int unsigned width_out);
        return width_in / width_out;
    endfunction

    // Legal pairs: both widths whole bytes, wide side an exact multiple of at least two narrow beats.
    function automatic bit params_ok(input int unsigned width_in, input int unsigned width_out);
        return (width_out != 0) && (width_in % 8 == 0) && (width_out % 8 == 0) &&
               (width_in % width_out == 0) && (width_in / width_out >= 2);
    endfunction

    function automatic int unsigned field_width(input int unsigned w);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/axi_stream_dw_downsizer.sv
// AXI-Stream width downsizer: one buffered wide beat is replayed as Ratio narrow beats, LSB slice first.
module axi_stream_dw_downsizer
    import axi_stream_pkg::*;
#(
    parameter int unsigned DataWidthIn  = 32,
    parameter int unsigned DataWidthOut = 8,
    parameter int unsigned IdWidth      = 0,
    parameter int unsigned DestWidth    = 0,
    parameter int unsigned UserWidth    = 0
) (
    input  logic                               clk_i,
    input  logic                               rst_i,

    input  logic                               in_tvalid_i,
    output logic                               in_tready_o,
    input  logic [DataWidthIn-1:0]             in_tdata_i,
    input  logic [DataWidthIn/8-1:0]           in_tstrb_i,
    input  logic [DataWidthIn/8-1:0]           in_tkeep_i,
    input  logic                               in_tlast_i,
    input  logic [field_width(IdWidth)-1:0]    in_tid_i,
    input  logic [field_width(DestWidth)-1:0]  in_tdest_i,
    input  logic [field_width(UserWidth)-1:0]  in_tuser_i,

    output logic                               out_tvalid_o,
    input  logic                               out_tready_i,
    output logic [DataWidthOut-1:0]            out_tdata_o,
    output logic [DataWidthOut/8-1:0]          out_tstrb_o,
    output logic [DataWidthOut/8-1:0]          out_tkeep_o,
    output logic                               out_tlast_o,
    output logic [field_width(IdWidth)-1:0]    out_tid_o,
    output logic [field_width(DestWidth)-1:0]  out_tdest_o,
    output logic [field_width(UserWidth)-1:0]  out_tuser_o
);

    localparam int unsigned Ratio    = calc_ratio(DataWidthIn, DataWidthOut);
    localparam int unsigned IdxWidth = $clog2(Ratio);
    localparam int unsigned StrbIn   = DataWidthIn / 8;
    localparam int unsigned StrbOut  = DataWidthOut / 8;
    localparam int unsigned IdW      = field_width(IdWidth);
    localparam int unsigned DestW    = field_width(DestWidth);
    localparam int unsigned UserW    = field_width(UserWidth);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(Ratio - 1);

    if (!params_ok(DataWidthIn, DataWidthOut)) begin : g_bad_params
        $error("axi_stream_dw_downsizer: illegal DataWidthIn/DataWidthOut combination");
    end

    logic                buf_valid;
    logic [IdxWidth-1:0] idx;
    logic [DataWidthIn-1:0] buf_data;
    logic [StrbIn-1:0]   buf_strb;
    logic [StrbIn-1:0]   buf_keep;
    logic                buf_last;
    logic [IdW-1:0]      buf_id;
    logic [DestW-1:0]    buf_dest;
    logic [UserW-1:0]    buf_user;

    logic in_hs;
    logic out_hs;
    logic last_slice;

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready,
    // and the output side holds every field stable while out_tvalid_o && !out_tready_i.
    assign last_slice   = (idx == LastIdx);
    assign out_hs       = buf_valid && out_tready_i;
    assign in_tready_o  = !buf_valid || (out_hs && last_slice);
    assign in_hs        = in_tvalid_i && in_tready_o;

    assign out_tvalid_o = buf_valid;
    assign out_tdata_o  = buf_data[idx*DataWidthOut +: DataWidthOut];
    assign out_tstrb_o  = buf_strb[idx*StrbOut +: StrbOut];
    assign out_tkeep_o  = buf_keep[idx*StrbOut +: StrbOut];
    assign out_tlast_o  = buf_last && last_slice;
    assign out_tid_o    = buf_id;
    assign out_tdest_o  = buf_dest;
    assign out_tuser_o  = buf_user;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_valid <= 1'b0;
            idx       <= '0;
            buf_data  <= '0;
            buf_strb  <= '0;
            buf_keep  <= '0;
            buf_last  <= 1'b0;
            buf_id    <= '0;
            buf_dest  <= '0;
            buf_user  <= '0;
        end else if (in_hs) begin
            // A new beat may land in the same cycle the final slice leaves, so no bubble appears.
            buf_valid <= 1'b1;
            idx       <= '0;
            buf_data  <= in_tdata_i;
            buf_strb  <= in_tstrb_i;
            buf_keep  <= in_tkeep_i;
            buf_last  <= in_tlast_i;
            buf_id    <= (IdWidth == 0)   ? '0 : in_tid_i;
            buf_dest  <= (DestWidth == 0) ? '0 : in_tdest_i;
            buf_user  <= (UserWidth == 0) ? '0 : in_tuser_i;
        end else if (out_hs) begin
            if (last_slice) begin
                idx       <= '0;
                buf_valid <= 1'b0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_dw_downsizer.sv
// Directed bench for the 32->8 downsizer: driver tasks, expected-queue scoreboard and a final report.
module tb_axi_stream_dw_downsizer;

    // Expected sub-beat entry: {last, strb, keep, data}
    localparam int W = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_tvalid = 1'b0;
    logic        in_tready;
    logic [31:0] in_tdata = '0;
    logic [3:0]  in_tstrb = '0;
    logic [3:0]  in_tkeep = '0;
    logic        in_tlast = 1'b0;
    logic        in_tid = 1'b0;
    logic        in_tdest = 1'b0;
    logic        in_tuser = 1'b0;
    logic        out_tvalid;
    logic        out_tready = 1'b1;
    logic [7:0]  out_tdata;
    logic        out_tstrb;
    logic        out_tkeep;
    logic        out_tlast;
    logic        out_tid;
    logic        out_tdest;
    logic        out_tuser;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi_stream_dw_downsizer #(
        .DataWidthIn (32),
        .DataWidthOut(8),
        .IdWidth     (0),
        .DestWidth   (0),
        .UserWidth   (0)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_tvalid_i (in_tvalid),
        .in_tready_o (in_tready),
        .in_tdata_i  (in_tdata),
        .in_tstrb_i  (in_tstrb),
        .in_tkeep_i  (in_tkeep),
        .in_tlast_i  (in_tlast),
        .in_tid_i    (in_tid),
        .in_tdest_i  (in_tdest),
        .in_tuser_i  (in_tuser),
        .out_tvalid_o(out_tvalid),
        .out_tready_i(out_tready),
        .out_tdata_o (out_tdata),
        .out_tstrb_o (out_tstrb),
        .out_tkeep_o (out_tkeep),
        .out_tlast_o (out_tlast),
        .out_tid_o   (out_tid),
        .out_tdest_o (out_tdest),
        .out_tuser_o (out_tuser)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: while anything is expected the output must be valid and show the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            check("tvalid", out_tvalid, exp_q.size() != 0);
            check("in_tready", in_tready, (exp_q.size() == 0) || (exp_q.size() == 1 && out_tready));
            check("tid_tdest_tuser", {out_tid, out_tdest, out_tuser}, 3'b000);
            if (out_tvalid && exp_q.size() != 0) begin
                check("tdata", out_tdata, exp_q[0][7:0]);
                check("tkeep", out_tkeep, exp_q[0][8]);
                check("tstrb", out_tstrb, exp_q[0][9]);
                check("tlast", out_tlast, exp_q[0][10]);
                if (out_tready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic s, input logic k, input logic l);
        exp_q.push_back({l, s, k, d});
    endtask

    task automatic push_1234(input logic last);
        push(8'hEF, 1'b1, 1'b1, 1'b0);
        push(8'h56, 1'b1, 1'b1, 1'b0);
        push(8'h34, 1'b1, 1'b1, 1'b0);
        push(8'h12, 1'b1, 1'b1, last);
    endtask

    // Returns one step after the accepting edge, with the input side idle again.
    task automatic send_beat(input logic [31:0] data, input logic [3:0] strb,
                             input logic [3:0] keep, input logic last);
        int waited;
        waited    = 0;
        in_tvalid = 1'b1;
        in_tdata  = data;
        in_tstrb  = strb;
        in_tkeep  = keep;
        in_tlast  = last;
        @(negedge clk);
        while (!in_tready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        check("in_accept", in_tready, 1'b1);
        tick();
        in_tvalid = 1'b0;
        in_tdata  = '0;
        in_tstrb  = '0;
        in_tkeep  = '0;
        in_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 64) begin
            tick();
            waited++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_tvalid", out_tvalid, 1'b0);
        check("rst_tlast", out_tlast, 1'b0);
        check("rst_in_tready", in_tready, 1'b1);
        tick();

        // Single beats, tlast 0 then 1
        send_beat(32'h1234_56EF, 4'hF, 4'hF, 1'b0);
        push_1234(1'b0);
        wait_drain();
        send_beat(32'h1234_56EF, 4'hF, 4'hF, 1'b1);
        push_1234(1'b1);
        wait_drain();

        // Back-to-back beats, no bubble
        send_beat(32'h1234_56EF, 4'hF, 4'hF, 1'b0);
        push_1234(1'b0);
        send_beat(32'h1234_56EF, 4'hF, 4'hF, 1'b1);
        push_1234(1'b1);
        wait_drain();

        // Late producer: four idle cycles between beats
        send_beat(32'h1234_56EF, 4'hF, 4'hF, 1'b0);
        push_1234(1'b0);
        wait_drain();
        repeat (4) tick();
        send_beat(32'h1234_56EF, 4'hF, 4'hF, 1'b1);
        push_1234(1'b1);
        wait_drain();

        // Consumer pauses one cycle on the first sub-beat of the second beat
        send_beat(32'h1234_56EF, 4'hF, 4'hF, 1'b0);
        push_1234(1'b0);
        send_beat(32'h1234_56EF, 4'hF, 4'hF, 1'b1);
        push_1234(1'b1);
        out_tready = 1'b0;
        @(negedge clk);
        check("stall_hold_ef", out_tdata, 8'hEF);
        check("stall_in_tready", in_tready, 1'b0);
        tick();
        out_tready = 1'b1;
        wait_drain();

        // Stalls on sub-beats 0 and 2
        send_beat(32'h1234_56EF, 4'hF, 4'hF, 1'b1);
        push_1234(1'b1);
        out_tready = 1'b0;
        tick();
        out_tready = 1'b1;
        tick();
        tick();
        out_tready = 1'b0;
        @(negedge clk);
        check("stall_hold_34", out_tdata, 8'h34);
        tick();
        out_tready = 1'b1;
        wait_drain();

        // Sparse strobes: zero-keep sub-beats are still emitted
        send_beat(32'hA5C3_0F1E, 4'b1011, 4'b0110, 1'b1);
        push(8'h1E, 1'b1, 1'b0, 1'b0);
        push(8'h0F, 1'b1, 1'b1, 1'b0);
        push(8'hC3, 1'b0, 1'b1, 1'b0);
        push(8'hA5, 1'b1, 1'b0, 1'b1);
        wait_drain();

        // Reset mid-packet after 0x56 leaves
        send_beat(32'h1234_56EF, 4'hF, 4'hF, 1'b1);
        push_1234(1'b1);
        tick();
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_tvalid", out_tvalid, 1'b0);
        check("mid_rst_in_tready", in_tready, 1'b1);
        tick();
        send_beat(32'h1234_56EF, 4'hF, 4'hF, 1'b0);
        push_1234(1'b0);
        wait_drain();

        repeat (2) tick();
        check("final_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
